// File: rtl/fifo_rr_stripe.sv
// Round-robin striped FIFO: LANES lane queues of DEPTH entries, global order preserved.
// Define FIFO_RR_LEVEL_EN to add the registered occupancy output `level`.
module fifo_rr_stripe #(
  parameter int unsigned WIDTH = 704,
  parameter int unsigned LANES = 2,
  parameter int unsigned DEPTH = 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_enq__ENA,
  input  logic [WIDTH-1:0] in_enq_v,
  output logic             in_enq__RDY,
  input  logic             out_deq__ENA,
  output logic             out_deq__RDY,
  output logic [WIDTH-1:0] out_first,
  output logic             out_first__RDY
`ifdef FIFO_RR_LEVEL_EN
  ,
  output logic [$clog2(LANES*DEPTH+1)-1:0] level
`endif
);

  localparam int unsigned LaneW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned IdxW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned Cap   = LANES * DEPTH;
  localparam int unsigned AddrW = (Cap > 1) ? $clog2(Cap) : 1;

  localparam logic [LaneW-1:0] LastLane = LaneW'(LANES - 1);
  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(DEPTH - 1);
  localparam logic [CntW-1:0]  FullCnt  = CntW'(DEPTH);

  logic [LaneW-1:0] r_wptr;
  logic [LaneW-1:0] r_rptr;
  logic [IdxW-1:0]  r_head    [LANES];
  logic [IdxW-1:0]  r_tail    [LANES];
  logic [CntW-1:0]  r_cnt     [LANES];
  logic [CntW-1:0]  w_cnt_nxt [LANES];
  logic [WIDTH-1:0] r_mem     [Cap];

  logic             w_enq_fire;
  logic             w_deq_fire;
  logic             w_deq_rdy;
  logic             w_all_empty;
  logic             w_all_full;
  logic [AddrW-1:0] w_waddr;
  logic [AddrW-1:0] w_raddr;

  function automatic logic [LaneW-1:0] lane_inc(input logic [LaneW-1:0] p);
    return (p == LastLane) ? '0 : p + LaneW'(1);
  endfunction

  function automatic logic [IdxW-1:0] idx_inc(input logic [IdxW-1:0] i);
    return (i == LastIdx) ? '0 : i + IdxW'(1);
  endfunction

  // Lanes are packed into one flat RAM, DEPTH consecutive words per lane.
  function automatic logic [AddrW-1:0] ram_addr(input logic [LaneW-1:0] lane,
                                                input logic [IdxW-1:0]  idx);
    return AddrW'(32'(lane) * DEPTH + 32'(idx));
  endfunction

  assign in_enq__RDY    = (r_cnt[r_wptr] != FullCnt);
  assign w_deq_rdy      = (r_cnt[r_rptr] != '0);
  assign out_deq__RDY   = w_deq_rdy;
  assign out_first__RDY = w_deq_rdy;

  assign w_enq_fire = in_enq__ENA && in_enq__RDY;
  assign w_deq_fire = out_deq__ENA && w_deq_rdy;

  assign w_waddr = ram_addr(r_wptr, r_tail[r_wptr]);
  assign w_raddr = ram_addr(r_rptr, r_head[r_rptr]);

  always_comb begin
    out_first = '0;
    if (w_deq_rdy) begin
      out_first = r_mem[w_raddr];
    end
  end

  // Same-lane enq+deq cancels out; different lanes move independently.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      w_cnt_nxt[l] = r_cnt[l];
      if (w_enq_fire && (r_wptr == LaneW'(l))) begin
        w_cnt_nxt[l] = w_cnt_nxt[l] + CntW'(1);
      end
      if (w_deq_fire && (r_rptr == LaneW'(l))) begin
        w_cnt_nxt[l] = w_cnt_nxt[l] - CntW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int unsigned l = 0; l < LANES; l++) begin
        r_cnt[l]  <= '0;
        r_head[l] <= '0;
        r_tail[l] <= '0;
      end
    end else begin
      if (w_enq_fire) begin
        r_tail[r_wptr] <= idx_inc(r_tail[r_wptr]);
        r_wptr         <= lane_inc(r_wptr);
      end
      if (w_deq_fire) begin
        r_head[r_rptr] <= idx_inc(r_head[r_rptr]);
        r_rptr         <= lane_inc(r_rptr);
      end
      for (int unsigned l = 0; l < LANES; l++) begin
        r_cnt[l] <= w_cnt_nxt[l];
      end
    end
  end

  // Payload RAM is deliberately left out of reset.
  always_ff @(posedge CLK) begin
    if (nRST && w_enq_fire) begin
      r_mem[w_waddr] <= in_enq_v;
    end
  end

`ifdef FIFO_RR_LEVEL_EN
  localparam int unsigned LvlW = $clog2(Cap + 1);

  logic [LvlW-1:0] r_level;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_level <= '0;
    end else if (w_enq_fire && !w_deq_fire) begin
      r_level <= r_level + LvlW'(1);
    end else if (w_deq_fire && !w_enq_fire) begin
      r_level <= r_level - LvlW'(1);
    end
  end

  assign level = r_level;
`endif

  always_comb begin
    w_all_empty = 1'b1;
    w_all_full  = 1'b1;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (r_cnt[l] != '0)     w_all_empty = 1'b0;
      if (r_cnt[l] != FullCnt) w_all_full = 1'b0;
    end
  end

  // Striping keeps the pointers aligned whenever every lane is empty or every lane is full.
  always_ff @(posedge CLK) begin
    if (nRST && (w_all_empty || w_all_full)) begin
      assert (r_rptr == r_wptr);
    end
  end

endmodule

// File: tb/tb_fifo_rr_stripe.sv
// Scoreboard bench for fifo_rr_stripe (WIDTH=8, LANES=3, DEPTH=2): a plain queue of
// capacity LANES*DEPTH predicts readiness, order and occupancy.
module tb_fifo_rr_stripe;

  localparam int unsigned Width = 8;
  localparam int unsigned Lanes = 3;
  localparam int unsigned Depth = 2;
  localparam int unsigned Cap   = Lanes * Depth;

  logic             CLK = 1'b0;
  logic             nRST = 1'b0;
  logic             in_enq__ENA = 1'b0;
  logic [Width-1:0] in_enq_v = '0;
  logic             in_enq__RDY;
  logic             out_deq__ENA = 1'b0;
  logic             out_deq__RDY;
  logic [Width-1:0] out_first;
  logic             out_first__RDY;
`ifdef FIFO_RR_LEVEL_EN
  logic [2:0]       level;
`endif

  fifo_rr_stripe #(
    .WIDTH(Width),
    .LANES(Lanes),
    .DEPTH(Depth)
  ) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .in_enq__ENA   (in_enq__ENA),
    .in_enq_v      (in_enq_v),
    .in_enq__RDY   (in_enq__RDY),
    .out_deq__ENA  (out_deq__ENA),
    .out_deq__RDY  (out_deq__RDY),
    .out_first     (out_first),
    .out_first__RDY(out_first__RDY)
`ifdef FIFO_RR_LEVEL_EN
    ,
    .level         (level)
`endif
  );

  always #5 CLK = ~CLK;

  int unsigned      n_checks = 0;
  int unsigned      n_pass   = 0;
  logic [Width-1:0] sb_q[$];
  int unsigned      mdl_cnt  = 0;
  bit               mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // One clock of stimulus; the reference queue advances on the edge the DUT samples.
  task automatic step(input logic e, input logic [Width-1:0] d, input logic q,
                      input logic rst_n);
    bit ef;
    bit df;
    in_enq__ENA  = e;
    in_enq_v     = d;
    out_deq__ENA = q;
    nRST         = rst_n;
    @(posedge CLK);
    if (!rst_n) begin
      mdl_cnt = 0;
      sb_q.delete();
    end else begin
      ef = e && (mdl_cnt < Cap);
      df = q && (mdl_cnt != 0);
      if (ef) sb_q.push_back(d);
      mdl_cnt = mdl_cnt + 32'(ef) - 32'(df);
    end
    #1;
  endtask

  task automatic drain(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b1);
  endtask

  // Monitor: compares DUT outputs mid-cycle against the reference state.
  initial begin
    forever begin
      @(negedge CLK);
      if (mon_en && nRST) begin
        check("enq_rdy", 32'(in_enq__RDY), 32'(mdl_cnt < Cap));
        check("deq_rdy", 32'(out_deq__RDY), 32'(mdl_cnt != 0));
        check("first_rdy", 32'(out_first__RDY), 32'(mdl_cnt != 0));
`ifdef FIFO_RR_LEVEL_EN
        check("level", 32'(level), mdl_cnt);
`endif
        if (!out_first__RDY) begin
          check("first_zero", 32'(out_first), 32'd0);
        end else if (sb_q.size() == 0) begin
          check("sb_underflow", sb_q.size(), 32'd1);
        end else begin
          check(out_deq__ENA ? "deq_data" : "head_data", 32'(out_first), 32'(sb_q[0]));
          if (out_deq__ENA) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    int unsigned pe;
    int unsigned pd;
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    mon_en = 1'b1;

    // Three entries striped one per lane, then drained to empty.
    step(1'b1, 8'h11, 1'b0, 1'b1);
    step(1'b1, 8'h22, 1'b0, 1'b1);
    step(1'b1, 8'h33, 1'b0, 1'b1);
    drain(3);
    step(1'b0, '0, 1'b0, 1'b1);

    // Overfill: the 7th entry is refused.
    for (int unsigned i = 1; i <= 7; i++) step(1'b1, 8'(i), 1'b0, 1'b1);
    drain(Cap + 1);

    // Streaming with both strobes held.
    for (int unsigned i = 0; i < 100; i++) step(1'b1, 8'(i), 1'b1, 1'b1);
    drain(Cap + 1);

    // Full: simultaneous enq+deq lets only the deq through.
    for (int unsigned i = 0; i < Cap; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b1);
    step(1'b1, 8'h50, 1'b1, 1'b1);
    step(1'b1, 8'h51, 1'b0, 1'b1);
    drain(Cap + 1);

    // Reset mid-operation with strobes active; next entry is the next dequeued.
    for (int unsigned i = 0; i < 4; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b1);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    drain(2);

    // Randomised phases with varying enq/deq bias and rare resets.
    for (int unsigned ph = 0; ph < 8; ph++) begin
      pe = $urandom_range(90, 10);
      pd = $urandom_range(90, 10);
      for (int unsigned c = 0; c < 500; c++) begin
        step(($urandom_range(99) < pe), 8'($urandom), ($urandom_range(99) < pd),
             ($urandom_range(299) != 0));
      end
    end

    drain(Cap + 1);
    check("final_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
